// File: rtl/seq_alu.sv
// Handshaked multi-cycle ALU: bitwise/add/sub in one clock, shifts and rotates
// one bit per clock, with a carry-flag register for multi-precision chaining.
module seq_alu #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    input  logic             use_flag,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] q,
    output logic             cout,
    output logic             zero,
    output logic             neg,
    output logic             ovf,
    output logic             cflag
);

    localparam int unsigned SHW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t           state_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] wreg_q;
    logic [SHW-1:0]   count_q;
    logic [2:0]       sop_q;
    logic             carry_q;
    logic [WIDTH-1:0] q_q;
    logic             cout_q;
    logic             zero_q;
    logic             neg_q;
    logic             ovf_q;
    logic             cflag_q;

    logic             c_eff;
    logic [SHW-1:0]   n;
    logic [WIDTH-1:0] bb;
    logic             cb;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] logic_r;
    logic [WIDTH-1:0] step_w;
    logic             step_c;
    logic             start_shift;
    logic             load;
    logic [WIDTH-1:0] q_d;
    logic             cout_d;
    logic             ovf_d;

    always_comb begin
        c_eff = use_flag ? cflag_q : cin;
        n     = b[SHW-1:0];
        bb    = op[1] ? ~b : b;
        // op[1:0]: 00 -> +0, 10 -> +1 (two's complement), x1 -> +c_eff
        cb    = op[0] ? c_eff : op[1];
        sum   = {1'b0, a} + {1'b0, bb} + {{WIDTH{1'b0}}, cb};

        case (op[1:0])
            2'b00:   logic_r = a & b;
            2'b01:   logic_r = a | b;
            2'b10:   logic_r = a ^ b;
            default: logic_r = ~(a & b);
        endcase

        // carry_q holds the RLC/RRC ring bit and doubles as "last bit out"
        case (sop_q)
            3'b001:  step_w = {wreg_q[WIDTH-2:0], wreg_q[WIDTH-1]};
            3'b010:  step_w = {wreg_q[WIDTH-2:0], carry_q};
            3'b100:  step_w = {1'b0, wreg_q[WIDTH-1:1]};
            3'b101:  step_w = {wreg_q[0], wreg_q[WIDTH-1:1]};
            3'b110:  step_w = {wreg_q[WIDTH-1], wreg_q[WIDTH-1:1]};
            3'b111:  step_w = {carry_q, wreg_q[WIDTH-1:1]};
            default: step_w = {wreg_q[WIDTH-2:0], 1'b0};
        endcase
        step_c = sop_q[2] ? wreg_q[0] : wreg_q[WIDTH-1];

        start_shift = (state_q == S_IDLE) && in_valid && op[3] && (n != '0);
        load = ((state_q == S_IDLE) && in_valid && !start_shift)
            || ((state_q == S_SHIFT) && (count_q == SHW'(1)));

        if (state_q == S_SHIFT) begin
            q_d    = step_w;
            cout_d = step_c;
            ovf_d  = 1'b0;
        end else if (op[3]) begin
            q_d    = a;
            cout_d = c_eff;
            ovf_d  = 1'b0;
        end else if (op[2]) begin
            q_d    = sum[WIDTH-1:0];
            cout_d = sum[WIDTH];
            ovf_d  = (a[WIDTH-1] == bb[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
        end else begin
            q_d    = logic_r;
            cout_d = 1'b0;
            ovf_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            wreg_q      <= '0;
            count_q     <= '0;
            sop_q       <= '0;
            carry_q     <= 1'b0;
            q_q         <= '0;
            cout_q      <= 1'b0;
            zero_q      <= 1'b0;
            neg_q       <= 1'b0;
            ovf_q       <= 1'b0;
            cflag_q     <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        in_ready_q <= 1'b0;
                        if (start_shift) begin
                            state_q <= S_SHIFT;
                            wreg_q  <= a;
                            carry_q <= c_eff;
                            count_q <= n;
                            sop_q   <= op[2:0];
                        end else begin
                            state_q     <= S_DONE;
                            out_valid_q <= 1'b1;
                        end
                    end
                end
                S_SHIFT: begin
                    wreg_q  <= step_w;
                    carry_q <= step_c;
                    count_q <= count_q - SHW'(1);
                    if (count_q == SHW'(1)) begin
                        state_q     <= S_DONE;
                        out_valid_q <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state_q     <= S_IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
            endcase

            if (load) begin
                q_q     <= q_d;
                cout_q  <= cout_d;
                zero_q  <= (q_d == '0);
                neg_q   <= q_d[WIDTH-1];
                ovf_q   <= ovf_d;
                cflag_q <= cout_d;
            end
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign q         = q_q;
    assign cout      = cout_q;
    assign zero      = zero_q;
    assign neg       = neg_q;
    assign ovf       = ovf_q;
    assign cflag     = cflag_q;

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu at WIDTH=2, 8 and 32 against an arithmetic
// reference model, plus hand-computed vectors at WIDTH=8.
module tb_seq_alu;

    typedef struct {
        logic [63:0] q;
        logic        c;
        logic        z;
        logic        n;
        logic        v;
        logic        f;
        int          lat;
    } res_t;

    logic        clk;
    logic        rst_n;
    logic [2:0]  in_valid_v;
    logic [31:0] a_s;
    logic [31:0] b_s;
    logic [3:0]  op_s;
    logic        use_flag_s;
    logic        cin_s;
    logic        out_ready_s;
    int          sel;

    logic        rdy2, ov2, co2, z2, n2, v2, cf2;
    logic [1:0]  q2;
    logic        rdy8, ov8, co8, z8, n8, v8, cf8;
    logic [7:0]  q8;
    logic        rdy32, ov32, co32, z32, n32, v32, cf32;
    logic [31:0] q32;

    logic        in_ready_m, out_valid_m, cout_m, zero_m, neg_m, ovf_m, cflag_m;
    logic [63:0] q_m;

    int          errors;
    int          checks;
    res_t        exp_q[$];
    logic [2:0]  mcflag;

    seq_alu #(.WIDTH(2)) u_w2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[0]), .in_ready(rdy2),
        .a(a_s[1:0]), .b(b_s[1:0]), .op(op_s), .use_flag(use_flag_s), .cin(cin_s),
        .out_valid(ov2), .out_ready(out_ready_s), .q(q2), .cout(co2),
        .zero(z2), .neg(n2), .ovf(v2), .cflag(cf2)
    );

    seq_alu #(.WIDTH(8)) u_w8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[1]), .in_ready(rdy8),
        .a(a_s[7:0]), .b(b_s[7:0]), .op(op_s), .use_flag(use_flag_s), .cin(cin_s),
        .out_valid(ov8), .out_ready(out_ready_s), .q(q8), .cout(co8),
        .zero(z8), .neg(n8), .ovf(v8), .cflag(cf8)
    );

    seq_alu #(.WIDTH(32)) u_w32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[2]), .in_ready(rdy32),
        .a(a_s), .b(b_s), .op(op_s), .use_flag(use_flag_s), .cin(cin_s),
        .out_valid(ov32), .out_ready(out_ready_s), .q(q32), .cout(co32),
        .zero(z32), .neg(n32), .ovf(v32), .cflag(cf32)
    );

    always_comb begin
        in_ready_m  = 1'b0;
        out_valid_m = 1'b0;
        q_m         = '0;
        cout_m      = 1'b0;
        zero_m      = 1'b0;
        neg_m       = 1'b0;
        ovf_m       = 1'b0;
        cflag_m     = 1'b0;
        case (sel)
            0: begin
                in_ready_m = rdy2; out_valid_m = ov2; q_m = 64'(q2); cout_m = co2;
                zero_m = z2; neg_m = n2; ovf_m = v2; cflag_m = cf2;
            end
            1: begin
                in_ready_m = rdy8; out_valid_m = ov8; q_m = 64'(q8); cout_m = co8;
                zero_m = z8; neg_m = n8; ovf_m = v8; cflag_m = cf8;
            end
            default: begin
                in_ready_m = rdy32; out_valid_m = ov32; q_m = 64'(q32); cout_m = co32;
                zero_m = z32; neg_m = n32; ovf_m = v32; cflag_m = cf32;
            end
        endcase
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic int width_of(input int inst);
        return (inst == 0) ? 2 : (inst == 1) ? 8 : 32;
    endfunction

    // Closed-form result of one operation: shifts are whole-word shifts and
    // ring rotations, not bit-by-bit iteration.
    function automatic res_t model(input int w, input logic [3:0] opv,
                                   input logic [63:0] av, input logic [63:0] bv,
                                   input logic ceff);
        res_t         r;
        logic [127:0] mask, rmask, A, B, Bx, S, R, ring;
        logic         c, v, cb;
        int           n;
        mask  = (128'd1 << w) - 128'd1;
        rmask = (mask << 1) | 128'd1;
        A     = {64'd0, av} & mask;
        B     = {64'd0, bv} & mask;
        n     = int'(bv[7:0]) % w;
        R     = '0;
        c     = 1'b0;
        v     = 1'b0;
        r.lat = 1;
        if (!opv[3]) begin
            if (!opv[2]) begin
                case (opv[1:0])
                    2'b00:   R = A & B;
                    2'b01:   R = A | B;
                    2'b10:   R = A ^ B;
                    default: R = ~(A & B) & mask;
                endcase
            end else begin
                Bx = opv[1] ? (~B & mask) : B;
                cb = (opv == 4'b0100) ? 1'b0 : (opv == 4'b0110) ? 1'b1 : ceff;
                S  = A + Bx + 128'(cb);
                R  = S & mask;
                c  = S[w];
                v  = (A[w-1] == Bx[w-1]) && (R[w-1] != A[w-1]);
            end
        end else if (n == 0) begin
            R = A;
            c = ceff;
        end else begin
            r.lat = n + 1;
            ring  = A | (128'(ceff) << w);
            case (opv[2:0])
                3'b001: begin R = ((A << n) | (A >> (w - n))) & mask; c = R[0]; end
                3'b010: begin
                    ring = ((ring << n) | (ring >> (w + 1 - n))) & rmask;
                    R = ring & mask; c = ring[w];
                end
                3'b100: begin R = A >> n; c = A[n-1]; end
                3'b101: begin R = ((A >> n) | (A << (w - n))) & mask; c = R[w-1]; end
                3'b110: begin
                    R = A >> n;
                    if (A[w-1]) R = R | ((mask << (w - n)) & mask);
                    c = A[n-1];
                end
                3'b111: begin
                    ring = ((ring >> n) | (ring << (w + 1 - n))) & rmask;
                    R = ring & mask; c = ring[w];
                end
                default: begin R = (A << n) & mask; c = A[w-n]; end
            endcase
        end
        r.q = R[63:0];
        r.c = c;
        r.z = (R == 0);
        r.n = R[w-1];
        r.v = v;
        r.f = c;
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    task automatic do_op(input int inst, input logic [3:0] opv, input logic [63:0] av,
                         input logic [63:0] bv, input logic uf, input logic ci,
                         input int hold, output res_t got);
        res_t e;
        int   lat;
        int   k;
        logic ceff;
        sel = inst;
        #1;
        k = 0;
        while (!in_ready_m && k < 10) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("in_ready_idle", 64'(in_ready_m), 64'd1);
        check("cflag_idle", 64'(cflag_m), 64'(mcflag[inst]));
        a_s        = av[31:0];
        b_s        = bv[31:0];
        op_s       = opv;
        use_flag_s = uf;
        cin_s      = ci;
        in_valid_v[inst] = 1'b1;
        @(posedge clk);
        ceff = uf ? mcflag[inst] : ci;
        e = model(width_of(inst), opv, av, bv, ceff);
        mcflag[inst] = e.c;
        exp_q.push_back(e);
        #1;
        in_valid_v = '0;
        a_s  = $urandom;
        b_s  = $urandom;
        op_s = 4'($urandom);
        cin_s = ~ci;
        lat = 1;
        while (!out_valid_m && lat < 80) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("latency", 64'(lat), 64'(e.lat));
        got.q = q_m; got.c = cout_m; got.z = zero_m; got.n = neg_m;
        got.v = ovf_m; got.f = cflag_m; got.lat = lat;
        if (!out_valid_m) begin
            exp_q.delete();
            return;
        end
        for (int h = 0; h < hold; h++) begin
            in_valid_v[inst] = (h < hold - 1);
            op_s = 4'($urandom);
            a_s  = $urandom;
            @(posedge clk);
            #1;
            check("busy_in_ready", 64'(in_ready_m), 64'd0);
            check("held_out_valid", 64'(out_valid_m), 64'd1);
        end
        in_valid_v  = '0;
        out_ready_s = 1'b1;
        @(posedge clk);
        void'(exp_q.pop_front());
        #1;
        out_ready_s = 1'b0;
        check("handoff_out_valid", 64'(out_valid_m), 64'd0);
        check("handoff_in_ready", 64'(in_ready_m), 64'd1);
    endtask

    res_t g;
    res_t g2;

    initial begin
        errors = 0;
        checks = 0;
        mcflag = '0;
        sel = 1;
        rst_n = 1'b0;
        in_valid_v = '0;
        a_s = '0;
        b_s = '0;
        op_s = '0;
        use_flag_s = 1'b0;
        cin_s = 1'b0;
        out_ready_s = 1'b0;

        fork
            forever begin
                @(negedge clk);
                if (rst_n && out_valid_m) begin
                    if (exp_q.size() == 0) begin
                        check("spurious_out_valid", 64'(out_valid_m), 64'd0);
                    end else begin
                        check("q", q_m, exp_q[0].q);
                        check("cout", 64'(cout_m), 64'(exp_q[0].c));
                        check("zero", 64'(zero_m), 64'(exp_q[0].z));
                        check("neg", 64'(neg_m), 64'(exp_q[0].n));
                        check("ovf", 64'(ovf_m), 64'(exp_q[0].v));
                        check("cflag", 64'(cflag_m), 64'(exp_q[0].f));
                        check("in_ready_while_done", 64'(in_ready_m), 64'd0);
                    end
                end
            end
        join_none

        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sel = i;
            #1;
            check("rst_in_ready", 64'(in_ready_m), 64'd1);
            check("rst_out_valid", 64'(out_valid_m), 64'd0);
            check("rst_q", q_m, 64'd0);
            check("rst_cflag", 64'(cflag_m), 64'd0);
        end

        // Subtract with signed overflow; leaves q and cflag nonzero for the reset test.
        do_op(1, 4'b0110, 64'h80, 64'h01, 1'b0, 1'b0, 0, g);
        check("sub_ovf_q", g.q, 64'h7F);
        check("sub_ovf_cout", 64'(g.c), 64'd1);
        check("sub_ovf_ovf", 64'(g.v), 64'd1);
        check("sub_ovf_neg", 64'(g.n), 64'd0);

        // Reset two edges into ROL 0x81 by 5.
        sel = 1;
        #1;
        a_s = 32'h81; b_s = 32'd5; op_s = 4'b1001; use_flag_s = 1'b0; cin_s = 1'b0;
        in_valid_v[1] = 1'b1;
        @(posedge clk);
        #1;
        in_valid_v = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_in_ready", 64'(in_ready_m), 64'd1);
        check("midrst_out_valid", 64'(out_valid_m), 64'd0);
        check("midrst_q", q_m, 64'd0);
        check("midrst_flags", {59'd0, cout_m, zero_m, neg_m, ovf_m, cflag_m}, 64'd0);
        mcflag = '0;
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("midrst_no_result", 64'(out_valid_m), 64'd0);
        check("midrst_idle", 64'(in_ready_m), 64'd1);

        do_op(1, 4'b0110, 64'h00, 64'h01, 1'b0, 1'b0, 0, g);
        check("sub_borrow_q", g.q, 64'hFF);
        check("sub_borrow_cout", 64'(g.c), 64'd0);
        check("sub_borrow_ovf", 64'(g.v), 64'd0);
        check("sub_borrow_neg", 64'(g.n), 64'd1);

        do_op(1, 4'b0100, 64'hFF, 64'h01, 1'b0, 1'b0, 0, g);
        check("add_lo_q", g.q, 64'h00);
        check("add_lo_cout", 64'(g.c), 64'd1);
        check("add_lo_zero", 64'(g.z), 64'd1);
        do_op(1, 4'b0101, 64'h12, 64'h34, 1'b1, 1'b0, 0, g);
        check("add_hi_q", g.q, 64'h47);
        check("add_hi_cflag", 64'(g.f), 64'd0);

        do_op(1, 4'b1110, 64'h90, 64'h03, 1'b0, 1'b0, 0, g);
        check("asr_q", g.q, 64'hF2);
        check("asr_cout", 64'(g.c), 64'd0);
        check("asr_latency", 64'(g.lat), 64'd4);

        do_op(1, 4'b1111, 64'h01, 64'h01, 1'b0, 1'b1, 0, g);
        check("rrc_q", g.q, 64'h80);
        check("rrc_cout", 64'(g.c), 64'd1);

        do_op(1, 4'b1101, 64'h5A, 64'h08, 1'b0, 1'b1, 0, g);
        check("n0_q", g.q, 64'h5A);
        check("n0_cout", 64'(g.c), 64'd1);
        check("n0_latency", 64'(g.lat), 64'd1);

        do_op(1, 4'b0010, 64'h3C, 64'hFF, 1'b0, 1'b0, 5, g);
        check("bp_q", g.q, 64'hC3);

        for (int inst = 0; inst < 3; inst++) begin
            int          w;
            logic [63:0] mask;
            logic [63:0] av;
            w    = width_of(inst);
            mask = (64'd1 << w) - 64'd1;
            av   = {32'd0, $urandom} & mask;
            do_op(inst, 4'b1001, av, 64'(w - 1), 1'b0, 1'b0, 0, g);
            check("rol_max_latency", 64'(g.lat), 64'(w));
            do_op(inst, 4'b1011, av, 64'(w - 1), 1'b0, 1'b1, 0, g);
            do_op(inst, 4'b1000, av, 64'(w - 1), 1'b0, 1'b1, 0, g2);
            check("rsv_as_lsl", g.q, g2.q);
            repeat (24) begin
                do_op(inst, 4'($urandom), {32'd0, $urandom} & mask,
                      {32'd0, $urandom} & mask, 1'($urandom), 1'($urandom),
                      int'($urandom_range(0, 2)), g);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
